// File: rtl/branch_hazard_ctrl.sv
// Branch/jump hazard scheduler for the ID stage: tracks EX/MEM destinations,
// drives branch-operand forwarding, load-use stalls, freeze handling and flush gating.
module branch_hazard_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_ID,
    input  logic                 is_branch,
    input  logic                 mem_stall_req,
    output logic [1:0]           FW_br_A,
    output logic [1:0]           FW_br_B,
    output logic                 stall_PC,
    output logic                 stall_IF_ID,
    output logic                 bubble_ID_EX,
    output logic                 stall_EX_MEM,
    output logic                 flush_IF_ID,
    output logic                 pc_redirect_en,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [1:0] FW_ORIGIN  = 2'b00;
    localparam logic [1:0] FW_EX_ALU  = 2'b01;
    localparam logic [1:0] FW_MEM_ALU = 2'b10;
    localparam logic [1:0] FW_MEM_MEM = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       ld;
    } slot_t;

    slot_t ex_reg;
    slot_t mem_reg;
    slot_t id_dec;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_beq_bne;
    logic       is_jr;
    logic       is_ctrl;
    logic [1:0] src_used;
    logic [1:0] src_hazard;
    logic       ld_stall;
    logic       redirect_raw;
    logic [2:0] cnt_inc;

    assign opcode = inst_ID[31:26];
    assign funct  = inst_ID[5:0];
    assign rs     = inst_ID[25:21];
    assign rt     = inst_ID[20:16];
    assign rd     = inst_ID[15:11];

    assign is_beq_bne = (opcode == 6'b000100) || (opcode == 6'b000101);
    assign is_jr      = (opcode == 6'b000000) && (funct == 6'b001000);
    assign is_ctrl    = is_beq_bne || is_jr ||
                        (opcode == 6'b000010) || (opcode == 6'b000011);
    assign src_used   = {is_beq_bne, is_beq_bne | is_jr};

    // Destination decode of the instruction about to enter EX.
    always_comb begin
        id_dec = '0;
        case (opcode)
            6'b000000: begin
                if (funct != 6'b001000) begin
                    id_dec.v   = 1'b1;
                    id_dec.dst = rd;
                end
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                id_dec.v   = 1'b1;
                id_dec.dst = rt;
            end
            6'b100011: begin
                id_dec.v   = 1'b1;
                id_dec.dst = rt;
                id_dec.ld  = 1'b1;
            end
            6'b000011: begin
                id_dec.v   = 1'b1;
                id_dec.dst = 5'd31;
            end
            default: id_dec = '0;
        endcase
        if (id_dec.dst == 5'd0) begin
            id_dec = '0;
        end
    end

    // Per-source forwarding: gi=0 is rs (operand A), gi=1 is rt (operand B).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [4:0] addr;
            logic [1:0] fw;
            logic       haz;

            assign addr = (gi == 0) ? rs : rt;

            always_comb begin
                fw  = FW_ORIGIN;
                haz = 1'b0;
                if (src_used[gi] && (addr != 5'd0)) begin
                    if (ex_reg.v && (ex_reg.dst == addr)) begin
                        if (ex_reg.ld) begin
                            haz = 1'b1;
                        end else begin
                            fw = FW_EX_ALU;
                        end
                    end else if (mem_reg.v && (mem_reg.dst == addr)) begin
                        fw = mem_reg.ld ? FW_MEM_MEM : FW_MEM_ALU;
                    end
                end
            end

            assign src_hazard[gi] = haz;
        end
    endgenerate

    assign ld_stall     = (|src_hazard) & ~mem_stall_req;
    assign redirect_raw = is_branch & ~ld_stall & ~mem_stall_req;

    // A stalled load drains into MEM while EX receives a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg  <= '0;
            mem_reg <= '0;
        end else if (!mem_stall_req) begin
            mem_reg <= ex_reg;
            ex_reg  <= ld_stall ? slot_t'('0) : id_dec;
        end
    end

    assign cnt_inc = {ld_stall, redirect_raw, is_ctrl & ~ld_stall & ~mem_stall_req};

    // Saturating statistics: 0 = branch, 1 = taken, 2 = stall.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign FW_br_A        = rst ? FW_ORIGIN : g_src[0].fw;
    assign FW_br_B        = rst ? FW_ORIGIN : g_src[1].fw;
    assign stall_PC       = ~rst & (mem_stall_req | ld_stall);
    assign stall_IF_ID    = ~rst & (mem_stall_req | ld_stall);
    assign bubble_ID_EX   = ~rst & ld_stall;
    assign stall_EX_MEM   = ~rst & mem_stall_req;
    assign pc_redirect_en = ~rst & redirect_raw;
    assign flush_IF_ID    = ~rst & redirect_raw;
    assign branch_cnt     = rst ? '0 : g_cnt[0].cnt_reg;
    assign taken_cnt      = rst ? '0 : g_cnt[1].cnt_reg;
    assign stall_cnt      = rst ? '0 : g_cnt[2].cnt_reg;

endmodule
